// File: rtl/ad_pkg.sv
// Shared types and default constants for the serial ADC front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ad_pkg;

    localparam int START_PHASE = 16;    // frame phase that launches a conversion
    localparam int CLK_DIV     = 20;    // clk cycles per adclk half-period
    localparam int NBITS       = 16;    // adclk cycles per conversion
    localparam int DATA_BITS   = 12;    // trailing bits kept as the result
    localparam int FRAME_LEN   = 8000;  // clk cycles per 200 us frame
    localparam int VOLT_W      = 16;    // width of the published result word

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } ad_state_e;

endpackage

// File: rtl/ad_avg4.sv
// Moving average of the last four conversion results, truncating divide by 4.
// Latency: avg_dat updates on the clk edge that samples in_vld high.
// Backpressure: none; in_vld is a single-cycle strobe accepted unconditionally.
module ad_avg4 #(
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic [DATA_BITS-1:0] in_dat,
    output logic [DATA_BITS-1:0] avg_dat
);

    localparam int SW = DATA_BITS + 2;

    // hist_q[0] is the newest sample, hist_q[3] the oldest; sum_q tracks their total
    logic [DATA_BITS-1:0] hist_q [4];
    logic [DATA_BITS-1:0] hist_d [4];
    logic [SW-1:0]        sum_q;
    logic [SW-1:0]        sum_d;
    logic [DATA_BITS-1:0] avg_q;
    logic [DATA_BITS-1:0] avg_d;

    // Running sum: add the incoming sample, drop the one falling out of the window
    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        avg_d  = avg_q;
        if (in_vld) begin
            hist_d[0] = in_dat;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
            hist_d[3] = hist_q[2];
            sum_d     = sum_q + {2'b00, in_dat} - {2'b00, hist_q[3]};
            avg_d     = DATA_BITS'(sum_d >> 2);
        end
    end

    // History, sum and output registers; reset clears history so early outputs average against zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            sum_q <= '0;
            avg_q <= '0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            avg_q  <= avg_d;
        end
    end

    assign avg_dat = avg_q;

endmodule

// File: rtl/ad_sampler.sv
// Once-per-frame SPI-style read of a 12-bit serial ADC, published as the 16-bit volt word.
// Latency: cs_n falls 1 cycle after the phase match is sampled; volt updates CLK_DIV*(2*NBITS+1) later (+1 with AD_AVG_EN).
// Backpressure: none; a phase match outside IDLE is ignored. Define AD_AVG_EN to publish a 4-sample average.
module ad_sampler
    import ad_pkg::*;
#(
    parameter int START_PHASE = ad_pkg::START_PHASE,
    parameter int CLK_DIV     = ad_pkg::CLK_DIV,
    parameter int NBITS       = ad_pkg::NBITS,
    parameter int DATA_BITS   = ad_pkg::DATA_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tri_200us,
    input  logic        ad_in,
    output logic        adclk,
    output logic        cs_n,
    output logic [15:0] volt
);

    localparam int             CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int             BW        = $clog2(NBITS + 1);
    localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(NBITS);
    localparam logic [15:0]    START_VAL = 16'(START_PHASE);

    ad_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic                 cs_n_q, cs_n_d;
    logic                 adclk_q, adclk_d;
    logic                 match_q, match_d;
    logic                 cnt_last;

    assign cnt_last = (cnt_q == DIV_LAST);

    // Conversion sequencer: next state, half-period timing, bit capture and pin levels
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        cs_n_d  = cs_n_q;
        adclk_d = adclk_q;
        match_d = (tri_200us == START_VAL);
        case (state_q)
            ST_IDLE: begin
                cs_n_d  = 1'b1;
                adclk_d = 1'b1;
                if (match_q) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_last) begin
                    state_d = ST_SHIFT_LO;
                    adclk_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (cnt_last) begin
                    // ADC drove the bit on our falling edge; take it as adclk rises
                    state_d = ST_SHIFT_HI;
                    adclk_d = 1'b1;
                    cnt_d   = '0;
                    sreg_d  = {sreg_q[DATA_BITS-2:0], ad_in};
                    bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_DONE;
                        cs_n_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        adclk_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                adclk_d = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset aborts any conversion and parks the pins high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            cs_n_q  <= 1'b1;
            adclk_q <= 1'b1;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            cs_n_q  <= cs_n_d;
            adclk_q <= adclk_d;
            match_q <= match_d;
        end
    end

    assign cs_n  = cs_n_q;
    assign adclk = adclk_q;

`ifdef AD_AVG_EN
    logic [DATA_BITS-1:0] avg_dat;

    // Result is stable in sreg_q during DONE; the averager registers it one cycle after cs_n rises
    ad_avg4 #(
        .DATA_BITS (DATA_BITS)
    ) u_avg (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (state_q == ST_DONE),
        .in_dat  (sreg_q),
        .avg_dat (avg_dat)
    );

    assign volt = 16'(avg_dat);
`else
    logic [15:0] volt_q, volt_d;
    logic        done_enter;

    assign done_enter = (state_q == ST_SHIFT_HI) && cnt_last && (bit_q == BIT_LAST);

    // Raw result is published on the same edge that raises cs_n
    always_comb begin
        volt_d = volt_q;
        if (done_enter) begin
            volt_d = 16'(sreg_q);
        end
    end

    // Result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            volt_q <= '0;
        end else begin
            volt_q <= volt_d;
        end
    end

    assign volt = volt_q;
`endif

endmodule

// File: tb/tb_ad_sampler.sv
module tb_ad_sampler;

    localparam int D      = 20;
    localparam int NB     = 16;
    localparam int CS_UP  = 1 + D * (2 * NB + 1);   // 661
`ifdef AD_AVG_EN
    localparam int VLAT   = CS_UP + 1;
`else
    localparam int VLAT   = CS_UP;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tri_200us;
    logic        ad_in;
    logic        adclk;
    logic        cs_n;
    logic [15:0] volt;

    int total = 0;
    int bad   = 0;

    logic [15:0] adc_word;
    int          adc_idx;
    logic [15:0] exp_volt;
`ifdef AD_AVG_EN
    int          hist [4];
`endif

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_raw;
        bit          dbl;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    ad_sampler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_200us (tri_200us),
        .ad_in     (ad_in),
        .adclk     (adclk),
        .cs_n      (cs_n),
        .volt      (volt)
    );

    // ADC model: restart on cs_n fall, present next bit MSB-first on each adclk fall
    always @(negedge cs_n) adc_idx = 0;
    always @(negedge adclk) begin
        if (cs_n == 1'b0 && adc_idx < 16) begin
            ad_in   = adc_word[15 - adc_idx];
            adc_idx = adc_idx + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
`ifdef AD_AVG_EN
        for (int i = 0; i < 4; i++) hist[i] = 0;
`endif
        exp_volt = 16'h0000;
    endtask

    // One conversion triggered by a single (or doubled) phase match; optional reset at cycle rst_at
    task automatic run_conv(input logic [15:0] word, input logic [15:0] exp_raw,
                            input bit dbl, input int rst_at, input string name);
        int fall_c = -1, rise_c = -1, first_lo = -1, last_edge = -1;
        int nfalls = 0, rises = 0, bad_w = 0, bad_idle = 0;
        logic prev_cs = 1'b1, prev_ck = 1'b1;
        logic [15:0] prev_exp = exp_volt;
        logic [15:0] new_exp;
        bit aborted = 1'b0;
`ifdef AD_AVG_EN
        int s = int'(exp_raw) + hist[0] + hist[1] + hist[2];
        new_exp = 16'(s >> 2);
`else
        new_exp = exp_raw;
`endif
        adc_word = word;
        @(posedge clk); #1;
        tri_200us = 16'd16;
        for (int c = 0; c <= 720; c++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                check({name, "_rst_cs_n"}, cs_n, 1);
                check({name, "_rst_adclk"}, adclk, 1);
                check({name, "_rst_volt"}, volt, 0);
                rst_n = 1'b1;
                model_clear();
                aborted = 1'b1;
                break;
            end
            if (prev_cs && !cs_n) begin
                nfalls++;
                if (fall_c < 0) fall_c = c;
            end
            if (!prev_cs && cs_n && rise_c < 0) rise_c = c;
            if (cs_n && !adclk) bad_idle++;
            if (adclk != prev_ck) begin
                if (!adclk && first_lo < 0) first_lo = c;
                else if (c - last_edge != D) bad_w++;
                last_edge = c;
                if (adclk && !cs_n) rises++;
            end
            if (c == VLAT - 1) check({name, "_volt_hold"}, volt, prev_exp);
            if (c == VLAT)     check({name, "_volt"}, volt, new_exp);
            prev_cs = cs_n;
            prev_ck = adclk;
            tri_200us = (dbl && (c == 0 || c == 299)) ? 16'd16 : 16'(17 + c);
            if (c == rst_at) rst_n = 1'b0;
        end
        if (!aborted) begin
            check({name, "_cs_fall_cyc"}, fall_c, 1);
            check({name, "_first_lo_cyc"}, first_lo, 1 + D);
            check({name, "_rises"}, rises, NB);
            check({name, "_level_width_errs"}, bad_w, 0);
            check({name, "_cs_rise_cyc"}, rise_c, CS_UP);
            check({name, "_conv_count"}, nfalls, 1);
            check({name, "_idle_adclk_low"}, bad_idle, 0);
            exp_volt = new_exp;
`ifdef AD_AVG_EN
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = int'(exp_raw);
`endif
        end
    endtask

    initial begin
        int viol;
        vecs[0] = '{16'h0ABC, 16'h0ABC, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0FFF, 1'b0};
        vecs[2] = '{16'h1234, 16'h0234, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'h8001, 16'h0001, 1'b1};
        vecs[5] = '{16'h5A5A, 16'h0A5A, 1'b0};

        rst_n     = 1'b0;
        tri_200us = 16'd0;
        ad_in     = 1'b0;
        adc_word  = 16'h0000;
        adc_idx   = 0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("reset_cs_n", cs_n, 1);
        check("reset_adclk", adclk, 1);
        check("reset_volt", volt, 0);
        rst_n = 1'b1;

        // Phase held at 0: nothing may ever happen
        viol = 0;
        repeat (10000) begin
            @(posedge clk); #1;
            if (cs_n !== 1'b1 || adclk !== 1'b1 || volt !== 16'h0000) viol++;
        end
        check("idle_no_conversion", viol, 0);

        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i].word, vecs[i].exp_raw, vecs[i].dbl, -1, $sformatf("vec%0d", i));
        end

        // Reset 300 cycles into a conversion, then a normal conversion
        run_conv(16'h0ABC, 16'h0ABC, 1'b0, 300, "rst_mid");
        run_conv(16'h0321, 16'h0321, 1'b0, -1, "after_rst");

`ifdef AD_AVG_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        run_conv(16'h0100, 16'h0100, 1'b0, -1, "avg1");
        check("avg1_hand", volt, 16'h0040);
        run_conv(16'h0200, 16'h0200, 1'b0, -1, "avg2");
        check("avg2_hand", volt, 16'h00C0);
        run_conv(16'h0300, 16'h0300, 1'b0, -1, "avg3");
        check("avg3_hand", volt, 16'h0180);
        run_conv(16'h0400, 16'h0400, 1'b0, -1, "avg4");
        check("avg4_hand", volt, 16'h0280);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
